peg_l2_rs_rx: RTL
=================

Name: peg_l2_rs_rx

Overview:
GMII receive Reconciliation Sublayer for the L2 MAC RX path at 1Gbps (8b, 125MHz). Converts raw gmii_rx_dv/er/rxd into the rs_rx_* packet stream that feeds the MAC RX parser. Uses a one-byte lookahead so that sop and eop are marked on the correct beats. Also handles error aggregation, max-length truncation and frame/error statistics.

Parameters:
PKT_DATA_W, 8, data byte width (only 8 supported)
MAX_FRM_LEN, 1530, max bytes per frame incl. preamble/SFD/FCS before truncation
LEN_CNTR_W, 12, byte counter width (must hold MAX_FRM_LEN)
CNTR_W, 16, statistics counter width

Ports:
clk  in  1  core clock, 125MHz, rising edge
rst_n  in  1  asynchronous active-low reset
config_l2_rs_rx_en  in  1  accept new frames; sampled only at frame start
config_l2_rs_rx_cntr_clr  in  1  synchronous clear of both stats counters
gmii_rx_dv  in  1  GMII receive data valid
gmii_rx_er  in  1  GMII receive error
gmii_rxd  in  8  GMII receive data
rs_rx_valid  out  1  beat valid
rs_rx_sop  out  1  first byte of frame
rs_rx_eop  out  1  last byte of frame
rs_rx_data  out  PKT_DATA_W  byte
rs_rx_ready  in  1  downstream ready (parser ties high)
rs_rx_error  out  1  frame errored; valid only with eop
l2_rs_rx_fsm_state  out  2  current FSM state
l2_rs_rx_frm_cntr  out  CNTR_W  frames delivered (eop beats)
l2_rs_rx_err_cntr  out  CNTR_W  errored frames

Behaviour:
- Clock/reset: one clock; reset asynchronous active-low. All outputs, counters, stage registers and FSM clear to 0 / IDLE on reset. Reset mid-frame discards the frame; no eop is generated.
- Stage0: gmii_rx_dv/er/rxd registered every clk into s0_dv/s0_er/s0_d.
- Hold: a single-byte register (hold_vld, hold_d, hold_sop). A byte is emitted from hold when the next byte arrives (eop=0) or when s0_dv falls (eop=1).
- Latency: fixed 3 clk from GMII pins to rs_rx_* for every byte, including the last one.
- Output signals are registered pulses. rs_rx_valid is high for exactly 1 clk per byte.
- FSM states: IDLE=0, DATA=1, DROP=2.
  - IDLE: on s0_dv=1 with config_l2_rs_rx_en=1, load hold with sop=1, set len=1, clear err_f/ovf_f, go to DATA. On s0_dv=1 with en=0, go to DROP.
  - DATA, s0_dv=1: emit hold (eop=0), load s0_d, len++. err_f |= s0_er.
  - DATA, s0_dv=0: emit hold with eop=1 and error=err_f|ovf_f, go to IDLE.
  - DATA, truncation: when the byte being loaded would make len = MAX_FRM_LEN+1, emit hold as eop with error=1, go to DROP. Frame output is MAX_FRM_LEN bytes.
  - DROP: emit nothing; go to IDLE when s0_dv=0.
- Single-byte frame: the one beat carries sop=1, eop=1.
- Back-to-back frames: dv low for 1 clk between frames is sufficient. The eop of frame N and the first load of frame N+1 never coincide on the output.
- en toggled mid-frame: no effect until the next IDLE.
- gmii_rx_er with dv=0 (carrier extension / false carrier) is ignored.
- Backpressure: GMII cannot be stalled. A beat with valid=1 & ready=0 is lost and sets ovf_f, which forces error on the frame's eop. If the eop beat itself is lost, the counters still update.
- Counters: frm_cntr +1 on every eop emission; err_cntr +1 on every eop emission with error=1. Both saturate at all-ones.
  - cntr_clr takes priority over increment in the same clk.
- Width rules: len uses LEN_CNTR_W bits and is compared unsigned; no wrap because truncation occurs first.

Decomposition:
- Add to peg_l2_params.v:
  - RS FSM state encodings (L2_RS_IDLE_S, L2_RS_DATA_S, L2_RS_DROP_S)
  - MAX_FRM_LEN default constant
  - GMII_FALSE_CARRIER = 8'h0E, reserved for future use
- One sub-module: peg_l2_sat_cntr (parameter W; inc, clr, count out, saturating). Instantiated twice for the statistics counters.

Test Plan:
- 72-byte frame (55×7, D5, 64 data), ready=1 -> 72 valid beats; sop on 0x55 at pin cycle +3; eop on last byte; error=0; frm_cntr=1.
- Same frame with gmii_rx_er=1 for 1 clk at byte 30 -> all 72 bytes delivered; eop error=1; err_cntr=1, frm_cntr=1.
- 1-byte frame 0xAB, then 1 clk gap, then 2-byte frame -> beat {sop=1,eop=1,0xAB}, then 2 beats with correct sop/eop; frm_cntr=2.
- 1600-byte frame with MAX_FRM_LEN=1530 -> exactly 1530 beats; eop error=1 on beat 1530; no further beats; FSM returns to IDLE after dv falls.
- en=0 at frame start then set to 1 mid-frame -> zero beats, FSM=DROP; next frame delivered normally. ready=0 for 1 beat mid-frame -> that beat lost, eop error=1.
- rst_n asserted at byte 20 -> outputs 0 immediately, FSM=IDLE, no eop; counters saturate at 16'hFFFF under forced preload; cntr_clr together with eop -> counter=0.

Source files
------------

// File: rtl/peg_l2_rs_rx_pkg.sv
// Shared definitions for the L2 GMII receive reconciliation sublayer.
//   - RS FSM state encodings and the enum used by the FSM
//   - default maximum frame length (preamble/SFD/FCS included)
//   - GMII false-carrier code, reserved for future use
package peg_l2_rs_rx_pkg;

  localparam logic [1:0] L2_RS_IDLE_S = 2'd0;
  localparam logic [1:0] L2_RS_DATA_S = 2'd1;
  localparam logic [1:0] L2_RS_DROP_S = 2'd2;

  localparam int unsigned MAX_FRM_LEN_DEF = 1530;

  localparam logic [7:0] GMII_FALSE_CARRIER = 8'h0E;

  typedef enum logic [1:0] {
    StIdle = L2_RS_IDLE_S,
    StData = L2_RS_DATA_S,
    StDrop = L2_RS_DROP_S
  } rs_state_e;

endpackage

// File: rtl/peg_l2_sat_cntr.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one (holds at all-ones)
//   clr        : synchronous clear, wins over inc
//   count      : current value
module peg_l2_sat_cntr #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/peg_l2_rs_rx.sv
// GMII receive reconciliation sublayer (1G, 8-bit).
// Turns gmii_rx_dv/er/rxd into the rs_rx_* beat stream for the MAC RX parser.
// A one-byte hold register provides lookahead so eop lands on the last byte;
// every byte takes a fixed 3 clk from pins to outputs.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   config_l2_rs_rx_en         : accept new frames (sampled at frame start)
//   config_l2_rs_rx_cntr_clr   : clear both statistics counters
//   gmii_rx_dv/er, gmii_rxd    : GMII receive pins
//   rs_rx_valid/sop/eop/data   : registered one-clk beat per byte
//   rs_rx_ready                : downstream ready; a refused beat is lost
//   rs_rx_error                : frame errored, meaningful with eop
//   l2_rs_rx_fsm_state         : IDLE=0, DATA=1, DROP=2
//   l2_rs_rx_frm_cntr/err_cntr : saturating frame / errored-frame counts
module peg_l2_rs_rx
  import peg_l2_rs_rx_pkg::*;
#(
  parameter int unsigned PKT_DATA_W  = 8,
  parameter int unsigned MAX_FRM_LEN = MAX_FRM_LEN_DEF,
  parameter int unsigned LEN_CNTR_W  = 12,
  parameter int unsigned CNTR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  config_l2_rs_rx_en,
  input  logic                  config_l2_rs_rx_cntr_clr,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  input  logic [7:0]            gmii_rxd,
  output logic                  rs_rx_valid,
  output logic                  rs_rx_sop,
  output logic                  rs_rx_eop,
  output logic [PKT_DATA_W-1:0] rs_rx_data,
  input  logic                  rs_rx_ready,
  output logic                  rs_rx_error,
  output logic [1:0]            l2_rs_rx_fsm_state,
  output logic [CNTR_W-1:0]     l2_rs_rx_frm_cntr,
  output logic [CNTR_W-1:0]     l2_rs_rx_err_cntr
);

  logic                  s0_dv, s0_er;
  logic [PKT_DATA_W-1:0] s0_d;
  rs_state_e             state_q;
  logic                  hold_vld_q, hold_sop_q;
  logic [PKT_DATA_W-1:0] hold_d_q;
  logic [LEN_CNTR_W-1:0] len_q;
  logic                  err_f_q, ovf_f_q;
  logic                  valid_q, sop_q, eop_q, error_q;
  logic [PKT_DATA_W-1:0] data_q;

  logic beat_lost, at_max, emit, emit_eop, emit_err;

  // Emission decode, shared by the output registers and the counters.
  always_comb begin
    beat_lost = valid_q & ~rs_rx_ready;
    at_max    = (len_q == LEN_CNTR_W'(MAX_FRM_LEN));
    emit      = 1'b0;
    emit_eop  = 1'b0;
    emit_err  = 1'b0;
    if (state_q == StData && hold_vld_q) begin
      emit = 1'b1;
      if (!s0_dv) begin
        emit_eop = 1'b1;
        // A beat refused on this very edge still taints the frame.
        emit_err = err_f_q | ovf_f_q | beat_lost;
      end else if (at_max) begin
        // Next byte would exceed the limit: close the frame as errored.
        emit_eop = 1'b1;
        emit_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_dv      <= 1'b0;
      s0_er      <= 1'b0;
      s0_d       <= '0;
      state_q    <= StIdle;
      hold_vld_q <= 1'b0;
      hold_sop_q <= 1'b0;
      hold_d_q   <= '0;
      len_q      <= '0;
      err_f_q    <= 1'b0;
      ovf_f_q    <= 1'b0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      error_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      s0_dv   <= gmii_rx_dv;
      s0_er   <= gmii_rx_er;
      s0_d    <= gmii_rxd;
      valid_q <= emit;
      sop_q   <= emit & hold_sop_q;
      eop_q   <= emit_eop;
      error_q <= emit_err;
      data_q  <= emit ? hold_d_q : '0;
      unique case (state_q)
        StIdle: begin
          hold_vld_q <= 1'b0;
          if (s0_dv) begin
            if (config_l2_rs_rx_en) begin
              hold_vld_q <= 1'b1;
              hold_sop_q <= 1'b1;
              hold_d_q   <= s0_d;
              len_q      <= LEN_CNTR_W'(1);
              err_f_q    <= 1'b0;
              ovf_f_q    <= 1'b0;
              state_q    <= StData;
            end else begin
              state_q <= StDrop;
            end
          end
        end
        StData: begin
          if (!s0_dv || at_max) begin
            hold_vld_q <= 1'b0;
            hold_sop_q <= 1'b0;
            state_q    <= s0_dv ? StDrop : StIdle;
          end else begin
            hold_d_q   <= s0_d;
            hold_sop_q <= 1'b0;
            len_q      <= len_q + LEN_CNTR_W'(1);
            err_f_q    <= err_f_q | s0_er;
            ovf_f_q    <= ovf_f_q | beat_lost;
          end
        end
        StDrop: begin
          if (!s0_dv) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rs_rx_valid        = valid_q;
  assign rs_rx_sop          = sop_q;
  assign rs_rx_eop          = eop_q;
  assign rs_rx_data         = data_q;
  assign rs_rx_error        = error_q;
  assign l2_rs_rx_fsm_state = state_q;

  peg_l2_sat_cntr #(.W(CNTR_W)) u_frm_cntr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (emit_eop),
    .clr   (config_l2_rs_rx_cntr_clr),
    .count (l2_rs_rx_frm_cntr)
  );

  peg_l2_sat_cntr #(.W(CNTR_W)) u_err_cntr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (emit_eop & emit_err),
    .clr   (config_l2_rs_rx_cntr_clr),
    .count (l2_rs_rx_err_cntr)
  );

endmodule
